// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe_if.sv
// gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe_if: data, valid, scan and occupancy signals of the reset-flop pipeline
interface gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int OW = $clog2(DEPTH + 1);
  logic             EN;
  logic [WIDTH-1:0] D;
  logic             DV;
  logic             SE;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic             QV;
  logic             SO;
  logic [OW-1:0]    OCC;
  modport master (output EN, D, DV, SE, SI, input Q, QV, SO, OCC);
  modport slave  (input EN, D, DV, SE, SI, output Q, QV, SO, OCC);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe.sv
// gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe: async-reset register pipeline with stall, valid tracking, occupancy and scan
module gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic CLK,
  input logic RN,
  input logic VDD,
  input logic VSS,
  gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe_if.slave p
);
  localparam int N  = WIDTH * DEPTH;
  localparam int OW = $clog2(DEPTH + 1);
  logic [N-1:0]     s;
  logic [DEPTH-1:0] v;
  logic [OW-1:0]    occ;
  logic             unused_supply;
  assign unused_supply = VDD ^ VSS;
  // Stages are packed with stage 0 in the low bits, so the scan chain and the advance are both left shifts
  always_ff @(posedge CLK or negedge RN)
    if (!RN) begin
      s   <= {DEPTH{RESET_VALUE}};
      v   <= '0;
      occ <= '0;
    end else if (p.SE) begin
      s <= N'({s, p.SI});
    end else if (p.EN) begin
      s   <= N'({s, p.D});
      v   <= DEPTH'({v, p.DV});
      occ <= occ + OW'(p.DV) - OW'(v[DEPTH-1]);
    end
  assign p.Q   = s[N-1 -: WIDTH];
  assign p.QV  = v[DEPTH-1];
  assign p.SO  = s[N-1];
  assign p.OCC = occ;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe.sv
// tb_gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe: directed checks of reset, streaming, stall, scan and the 1x1 configuration
module tb_gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe;
  logic clk = 1'b0;
  logic rn  = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] pat = 32'hDEADBEEF;
  logic [31:0] old = 32'h21222324;
  always #5 clk = ~clk;
  gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe_if #(.WIDTH(8), .DEPTH(4)) m ();
  gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe_if #(.WIDTH(1), .DEPTH(1)) g ();
  gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) u_m (
    .CLK(clk), .RN(rn), .VDD(1'b1), .VSS(1'b0), .p(m.slave));
  gf180mcu_fd_sc_mcu7t5v0__dffrnq_pipe #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) u_g (
    .CLK(clk), .RN(rn), .VDD(1'b1), .VSS(1'b0), .p(g.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string tag, input logic [7:0] q, input logic qv, input logic [2:0] occ);
    chk({tag, ".q"}, 32'(m.Q), 32'(q));
    chk({tag, ".qv"}, 32'(m.QV), 32'(qv));
    chk({tag, ".occ"}, 32'(m.OCC), 32'(occ));
  endtask
  task automatic adv(input logic [7:0] d, input logic dv);
    m.D  = d;
    m.DV = dv;
    tick();
  endtask
  task automatic gst(input string tag, input logic q, input logic qv);
    chk({tag, ".q"}, 32'(g.Q), 32'(q));
    chk({tag, ".qv"}, 32'(g.QV), 32'(qv));
    chk({tag, ".occ"}, 32'(g.OCC), 32'(qv));
    chk({tag, ".so"}, 32'(g.SO), 32'(q));
  endtask
  initial begin
    m.EN = 0; m.D = 0; m.DV = 0; m.SE = 0; m.SI = 0;
    g.EN = 0; g.D = 0; g.DV = 0; g.SE = 0; g.SI = 0;
    @(posedge clk);
    #2 rn = 1'b0;
    #2;
    st("rst", 8'hA5, 0, 0);
    chk("rst.so", 32'(m.SO), 1);
    gst("grst", 0, 0);
    #2 rn = 1'b1;
    repeat (3) tick();
    st("idle", 8'hA5, 0, 0);
    m.EN = 1;
    for (int i = 1; i <= 4; i++) begin
      adv(8'(i), 1);
      st("fill", (i == 4) ? 8'h01 : 8'hA5, i == 4, 3'(i));
    end
    adv(8'h05, 1); st("stream5", 8'h02, 1, 4);
    adv(8'h06, 1); st("stream6", 8'h03, 1, 4);
    m.EN = 0;
    m.D  = 8'hFF;
    repeat (5) begin
      tick();
      st("stall", 8'h03, 1, 4);
    end
    m.EN = 1;
    adv(8'h07, 1); st("resume7", 8'h04, 1, 4);
    adv(8'h08, 1); st("resume8", 8'h05, 1, 4);
    adv(8'h10, 0); st("drain1", 8'h06, 1, 3);
    adv(8'h11, 0); st("drain2", 8'h07, 1, 2);
    adv(8'h12, 0); st("drain3", 8'h08, 1, 1);
    adv(8'h13, 0); st("drain4", 8'h10, 0, 0);
    adv(8'h14, 0); st("empty", 8'h11, 0, 0);
    adv(8'h21, 1); st("mix1", 8'h12, 0, 1);
    adv(8'h22, 0); st("mix2", 8'h13, 0, 1);
    adv(8'h23, 1); st("mix3", 8'h14, 0, 2);
    adv(8'h24, 1); st("mix4", 8'h21, 1, 3);
    m.EN = 0;
    m.SE = 1;
    chk("scan.so0", 32'(m.SO), 32'(old[31]));
    for (int i = 0; i < 32; i++) begin
      m.SI = pat[31-i];
      tick();
      if (i < 31) chk("scan.so", 32'(m.SO), 32'(old[30-i]));
    end
    st("scan", 8'hDE, 1, 3);
    chk("scan.so", 32'(m.SO), 1);
    m.SE = 0;
    m.EN = 1;
    adv(8'h30, 0); st("post1", 8'hAD, 0, 2);
    adv(8'h31, 0); st("post2", 8'hBE, 1, 2);
    adv(8'h32, 0); st("post3", 8'hEF, 1, 1);
    adv(8'h41, 1); st("occ1", 8'h30, 0, 1);
    adv(8'h42, 1); st("occ2", 8'h31, 0, 2);
    adv(8'h43, 1); st("occ3", 8'h32, 0, 3);
    m.SE = 1;
    m.SI = 1;
    repeat (16) tick();
    chk("half.occ", 32'(m.OCC), 3);
    #2 rn = 1'b0;
    #1;
    st("rst2", 8'hA5, 0, 0);
    chk("rst2.so", 32'(m.SO), 1);
    #2 rn = 1'b1;
    m.SE = 0;
    adv(8'h5A, 1); st("new1", 8'hA5, 0, 1);
    adv(8'h00, 0); st("new2", 8'hA5, 0, 1);
    adv(8'h00, 0); st("new3", 8'hA5, 0, 1);
    adv(8'h00, 0); st("new4", 8'h5A, 1, 1);
    adv(8'h00, 0); st("new5", 8'h00, 0, 0);
    g.EN = 1; g.D = 1; g.DV = 1;
    tick(); gst("g1", 1, 1);
    g.D = 0; g.DV = 0;
    tick(); gst("g0", 0, 0);
    g.D = 1; g.DV = 1;
    tick(); gst("g1b", 1, 1);
    g.EN = 0; g.D = 0; g.DV = 0;
    tick(); gst("ghold", 1, 1);
    g.SE = 1; g.SI = 0;
    tick(); gst("gscan", 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
